// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the MEM stage: memory op codes, FSM states and
// lane/alignment predicates used by both the stage and the load extender.
package mem_access_pkg;

   typedef enum logic [3:0] {
      NONE = 4'd0,
      LB,
      LBU,
      LH,
      LHU,
      LW,
      SB,
      SH,
      SW
   } mem_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int LANES = 4;

   function automatic logic is_load(input mem_op_t op);
      return op inside {LB, LBU, LH, LHU, LW};
   endfunction

   function automatic logic is_store(input mem_op_t op);
      return op inside {SB, SH, SW};
   endfunction

   function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lane);
      case (op)
         LH, LHU, SH: return lane[0];
         LW, SW:      return |lane;
         default:     return 1'b0;
      endcase
   endfunction

   // Halfword selection looks only at lane[1], so a stray lane[0] is ignored.
   function automatic logic [LANES-1:0] lane_enable(input mem_op_t op, input logic [1:0] lane);
      case (op)
         LB, LBU, SB: return 4'b0001 << lane;
         LH, LHU, SH: return lane[1] ? 4'b1100 : 4'b0011;
         default:     return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Selects the addressed byte/half lane of a little-endian load word and
// sign- or zero-extends it according to the load op.
module load_extend
   import mem_access_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  lane,
   input  mem_op_t     op,
   output logic [31:0] data
);

   logic [31:0] shifted;
   logic [7:0]  byte_val;
   logic [15:0] half_val;

   always_comb begin
      shifted  = rdata >> {lane, 3'b000};
      byte_val = shifted[7:0];
      half_val = lane[1] ? rdata[31:16] : rdata[15:0];
      case (op)
         LB:      data = {{24{byte_val[7]}}, byte_val};
         LBU:     data = {24'h000000, byte_val};
         LH:      data = {{16{half_val[15]}}, half_val};
         LHU:     data = {16'h0000, half_val};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MIPS MEM stage: stage register, req/ack data-memory FSM and load extension.
// Optional misaligned-access trap is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      valid_EX,
   input  logic [DATA_WIDTH-1:0]     data_out_EX,
   input  logic [DATA_WIDTH-1:0]     rdata_2_EX,
   input  logic [REG_ADDR_WIDTH-1:0] target_EX,
   input  logic                      we_reg_EX,
   input  mem_op_t                   mem_op_EX,
   input  logic [DATA_WIDTH-1:0]     hi_EX,
   input  logic [DATA_WIDTH-1:0]     lo_EX,
   input  logic                      we_hi,
   input  logic                      we_lo,
   output logic                      stall_req,
   output logic                      valid_MEM,
   output logic [DATA_WIDTH-1:0]     data_out_MEM,
   output logic [REG_ADDR_WIDTH-1:0] target_MEM,
   output logic                      we_reg_MEM,
   output logic [DATA_WIDTH-1:0]     hi_MEM,
   output logic [DATA_WIDTH-1:0]     lo_MEM,
   output logic                      we_hi_MEM,
   output logic                      we_lo_MEM,
   output logic                      addr_err,
   output logic                      dmem_req,
   output logic                      dmem_we,
   output logic [DATA_WIDTH-1:0]     dmem_addr,
   output logic [LANES-1:0]          dmem_be,
   output logic [DATA_WIDTH-1:0]     dmem_wdata,
   input  logic [DATA_WIDTH-1:0]     dmem_rdata,
   input  logic                      dmem_ack
);

   state_t                    state;
   logic                      r_valid;
   logic                      r_we_reg;
   logic                      r_we_hi;
   logic                      r_we_lo;
   mem_op_t                   r_op;
   logic [DATA_WIDTH-1:0]     load_data;
   logic [DATA_WIDTH-1:0]     store_data;
   logic                      ex_misaligned;
   logic                      start_access;

`ifdef MEM_ALIGN_CHECK_EN
   logic r_err;
   assign ex_misaligned = is_misaligned(mem_op_EX, data_out_EX[1:0]);
   assign addr_err      = valid_MEM & r_err;
`else
   assign ex_misaligned = 1'b0;
   assign addr_err      = 1'b0;
`endif

   assign start_access = valid_EX && (mem_op_EX != NONE) && !ex_misaligned;

   always_comb begin
      case (mem_op_EX)
         SB:      store_data = {4{rdata_2_EX[7:0]}};
         SH:      store_data = {2{rdata_2_EX[15:0]}};
         default: store_data = rdata_2_EX;
      endcase
   end

   // The stage register still holds the effective address while BUSY, so its
   // low bits pick the load lane.
   load_extend u_load_extend (
      .rdata (dmem_rdata),
      .lane  (data_out_MEM[1:0]),
      .op    (r_op),
      .data  (load_data)
   );

   assign stall_req  = (state == BUSY);
   assign valid_MEM  = r_valid && (state == IDLE);
   assign we_reg_MEM = valid_MEM && r_we_reg && !addr_err;
   assign we_hi_MEM  = valid_MEM && r_we_hi;
   assign we_lo_MEM  = valid_MEM && r_we_lo;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         r_valid      <= 1'b0;
         r_we_reg     <= 1'b0;
         r_we_hi      <= 1'b0;
         r_we_lo      <= 1'b0;
         r_op         <= NONE;
         data_out_MEM <= '0;
         target_MEM   <= '0;
         hi_MEM       <= '0;
         lo_MEM       <= '0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_be      <= '0;
         dmem_wdata   <= '0;
`ifdef MEM_ALIGN_CHECK_EN
         r_err        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               r_valid      <= valid_EX;
               r_we_reg     <= we_reg_EX;
               r_we_hi      <= we_hi;
               r_we_lo      <= we_lo;
               r_op         <= mem_op_EX;
               data_out_MEM <= data_out_EX;
               target_MEM   <= target_EX;
               hi_MEM       <= hi_EX;
               lo_MEM       <= lo_EX;
`ifdef MEM_ALIGN_CHECK_EN
               r_err        <= valid_EX && (mem_op_EX != NONE) && ex_misaligned;
`endif
               if (start_access) begin
                  state      <= BUSY;
                  dmem_req   <= 1'b1;
                  dmem_we    <= is_store(mem_op_EX);
                  dmem_addr  <= {data_out_EX[DATA_WIDTH-1:2], 2'b00};
                  dmem_be    <= lane_enable(mem_op_EX, data_out_EX[1:0]);
                  dmem_wdata <= store_data;
               end
            end
            BUSY: begin
               if (dmem_ack) begin
                  state    <= IDLE;
                  dmem_req <= 1'b0;
                  if (is_load(r_op)) begin
                     data_out_MEM <= load_data;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: scoreboard of expected stage results,
// bench-driven dmem_ack with programmable latency. Honours MEM_ALIGN_CHECK_EN.
module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_EX = 1'b0;
   logic [31:0] data_out_EX = '0;
   logic [31:0] rdata_2_EX = '0;
   logic [4:0]  target_EX = '0;
   logic        we_reg_EX = 1'b0;
   mem_op_t     mem_op_EX = NONE;
   logic [31:0] hi_EX = '0;
   logic [31:0] lo_EX = '0;
   logic        we_hi = 1'b0;
   logic        we_lo = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        dmem_ack = 1'b0;

   logic        stall_req, valid_MEM, we_reg_MEM, we_hi_MEM, we_lo_MEM, addr_err;
   logic        dmem_req, dmem_we;
   logic [31:0] data_out_MEM, hi_MEM, lo_MEM, dmem_addr, dmem_wdata;
   logic [4:0]  target_MEM;
   logic [3:0]  dmem_be;

   always #5 clk = ~clk;

   mem_access dut (
      .clk          (clk),
      .rst          (rst),
      .valid_EX     (valid_EX),
      .data_out_EX  (data_out_EX),
      .rdata_2_EX   (rdata_2_EX),
      .target_EX    (target_EX),
      .we_reg_EX    (we_reg_EX),
      .mem_op_EX    (mem_op_EX),
      .hi_EX        (hi_EX),
      .lo_EX        (lo_EX),
      .we_hi        (we_hi),
      .we_lo        (we_lo),
      .stall_req    (stall_req),
      .valid_MEM    (valid_MEM),
      .data_out_MEM (data_out_MEM),
      .target_MEM   (target_MEM),
      .we_reg_MEM   (we_reg_MEM),
      .hi_MEM       (hi_MEM),
      .lo_MEM       (lo_MEM),
      .we_hi_MEM    (we_hi_MEM),
      .we_lo_MEM    (we_lo_MEM),
      .addr_err     (addr_err),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_be      (dmem_be),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata),
      .dmem_ack     (dmem_ack)
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  target;
      logic        we_reg;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   int          obs_stall;
   logic        obs_we;
   logic [31:0] obs_addr;
   logic [31:0] obs_wdata;
   logic [3:0]  obs_be;
   logic        obs_stable;
   logic        obs_early_valid;
   bit          seen;

   task automatic drive_ex(input logic v, input mem_op_t op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] tgt, input logic we);
      valid_EX    = v;
      mem_op_EX   = op;
      data_out_EX = addr;
      rdata_2_EX  = wd;
      target_EX   = tgt;
      we_reg_EX   = we;
   endtask

   task automatic bubble();
      drive_ex(1'b0, NONE, 32'h0, 32'h0, 5'd0, 1'b0);
      we_hi = 1'b0;
      we_lo = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge following the ack edge.
   task automatic run_mem(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] tgt, input logic we, input int lat,
                          input logic [31:0] rd);
      drive_ex(1'b1, op, addr, wd, tgt, we);
      @(posedge clk);
      @(negedge clk);
      bubble();
      obs_we          = dmem_we;
      obs_addr        = dmem_addr;
      obs_be          = dmem_be;
      obs_wdata       = dmem_wdata;
      obs_stable      = dmem_req;
      obs_stall       = 0;
      obs_early_valid = 1'b0;
      for (int i = 0; i < lat; i++) begin
         if (i > 0) @(negedge clk);
         if (stall_req === 1'b1) obs_stall++;
         if (valid_MEM !== 1'b0) obs_early_valid = 1'b1;
         if (dmem_req !== 1'b1 || dmem_we !== obs_we || dmem_addr !== obs_addr ||
             dmem_be !== obs_be || dmem_wdata !== obs_wdata) obs_stable = 1'b0;
         if (i == lat - 1) begin
            dmem_ack   = 1'b1;
            dmem_rdata = rd;
         end
      end
      @(posedge clk);
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h5A5A5A5A;
   endtask

   task automatic wait_valid(output bit ok);
      for (int i = 0; i < 8 && valid_MEM !== 1'b1; i++) @(negedge clk);
      ok = (valid_MEM === 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bubble();
      dmem_ack = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total_cnt++; if (valid_MEM !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", valid_MEM); else pass_cnt++;
      total_cnt++; if (dmem_req !== 1'b0) $display("[TB] FAIL reset_req: got %b want 0", dmem_req); else pass_cnt++;
      total_cnt++; if (stall_req !== 1'b0) $display("[TB] FAIL reset_stall: got %b want 0", stall_req); else pass_cnt++;
      total_cnt++; if (data_out_MEM !== 32'h0) $display("[TB] FAIL reset_data: got %h want 0", data_out_MEM); else pass_cnt++;
      total_cnt++; if ({we_reg_MEM, we_hi_MEM, we_lo_MEM, addr_err} !== 4'b0) $display("[TB] FAIL reset_flags: got %b want 0000", {we_reg_MEM, we_hi_MEM, we_lo_MEM, addr_err}); else pass_cnt++;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      dmem_ack = 1'b0;
      total_cnt++; if ({valid_MEM, stall_req, dmem_req} !== 3'b000) $display("[TB] FAIL late_ack: got %b want 000", {valid_MEM, stall_req, dmem_req}); else pass_cnt++;
   endtask

   task automatic test_passthrough();
      drive_ex(1'b1, NONE, 32'h00000007, 32'h0, 5'd3, 1'b1);
      hi_EX = 32'h11112222;
      lo_EX = 32'h33334444;
      we_hi = 1'b1;
      exp_q.push_back('{32'h00000007, 5'd3, 1'b1});
      @(posedge clk);
      @(negedge clk);
      bubble();
      total_cnt++; if (stall_req !== 1'b0) $display("[TB] FAIL alu_stall: got %b want 0", stall_req); else pass_cnt++;
      total_cnt++; if (valid_MEM !== 1'b1) $display("[TB] FAIL alu_valid: got %b want 1", valid_MEM); else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++; if (data_out_MEM !== e.data) $display("[TB] FAIL alu_data: got %h want %h", data_out_MEM, e.data); else pass_cnt++;
      total_cnt++; if (target_MEM !== e.target) $display("[TB] FAIL alu_target: got %0d want %0d", target_MEM, e.target); else pass_cnt++;
      total_cnt++; if (we_reg_MEM !== e.we_reg) $display("[TB] FAIL alu_we_reg: got %b want %b", we_reg_MEM, e.we_reg); else pass_cnt++;
      total_cnt++; if ({hi_MEM, lo_MEM} !== {32'h11112222, 32'h33334444}) $display("[TB] FAIL alu_hilo: got %h_%h want 11112222_33334444", hi_MEM, lo_MEM); else pass_cnt++;
      total_cnt++; if ({we_hi_MEM, we_lo_MEM} !== 2'b10) $display("[TB] FAIL alu_we_hilo: got %b want 10", {we_hi_MEM, we_lo_MEM}); else pass_cnt++;
      @(posedge clk);
      @(negedge clk);
      total_cnt++; if ({valid_MEM, we_hi_MEM} !== 2'b00) $display("[TB] FAIL alu_bubble: got %b want 00", {valid_MEM, we_hi_MEM}); else pass_cnt++;
   endtask

   task automatic test_lw();
      exp_q.push_back('{32'hDEADBEEF, 5'd5, 1'b1});
      run_mem(LW, 32'h00000100, 32'h0, 5'd5, 1'b1, 3, 32'hDEADBEEF);
      total_cnt++; if (obs_stall != 3) $display("[TB] FAIL lw_stall_cycles: got %0d want 3", obs_stall); else pass_cnt++;
      total_cnt++; if (obs_be !== 4'b1111) $display("[TB] FAIL lw_be: got %b want 1111", obs_be); else pass_cnt++;
      total_cnt++; if ({obs_we, obs_addr} !== {1'b0, 32'h00000100}) $display("[TB] FAIL lw_req: got we=%b addr=%h want we=0 addr=00000100", obs_we, obs_addr); else pass_cnt++;
      total_cnt++; if (obs_stable !== 1'b1) $display("[TB] FAIL lw_stable: got %b want 1", obs_stable); else pass_cnt++;
      total_cnt++; if (obs_early_valid !== 1'b0) $display("[TB] FAIL lw_early_valid: got %b want 0", obs_early_valid); else pass_cnt++;
      total_cnt++; if ({stall_req, dmem_req} !== 2'b00) $display("[TB] FAIL lw_release: got %b want 00", {stall_req, dmem_req}); else pass_cnt++;
      wait_valid(seen);
      total_cnt++; if (!seen) $display("[TB] FAIL lw_valid_timeout: got 0 want 1"); else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++; if (data_out_MEM !== e.data) $display("[TB] FAIL lw_data: got %h want %h", data_out_MEM, e.data); else pass_cnt++;
      total_cnt++; if ({target_MEM, we_reg_MEM} !== {e.target, e.we_reg}) $display("[TB] FAIL lw_wb: got %0d/%b want %0d/%b", target_MEM, we_reg_MEM, e.target, e.we_reg); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (valid_MEM !== 1'b0) $display("[TB] FAIL lw_single_pulse: got %b want 0", valid_MEM); else pass_cnt++;
   endtask

   task automatic test_loads();
      mem_op_t     ops[6]   = '{LB, LBU, LH, LHU, LB, LBU};
      logic [31:0] addrs[6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100};
      logic [31:0] rds[6]   = '{32'h80000000, 32'h80000000, 32'h80010000, 32'h80010000, 32'h00007F00, 32'h000000F0};
      logic [31:0] wants[6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'h0000007F, 32'h000000F0};
      logic [3:0]  bes[6]   = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0010, 4'b0001};
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back('{wants[i], 5'(i + 8), 1'b1});
         run_mem(ops[i], addrs[i], 32'h0, 5'(i + 8), 1'b1, 1 + (i % 2), rds[i]);
         total_cnt++; if (obs_be !== bes[i]) $display("[TB] FAIL load%0d_be: got %b want %b", i, obs_be, bes[i]); else pass_cnt++;
         wait_valid(seen);
         total_cnt++; if (!seen) $display("[TB] FAIL load%0d_valid_timeout: got 0 want 1", i); else pass_cnt++;
         e = exp_q.pop_front();
         total_cnt++; if (data_out_MEM !== e.data) $display("[TB] FAIL load%0d_data: got %h want %h", i, data_out_MEM, e.data); else pass_cnt++;
      end
   endtask

   task automatic test_stores();
      mem_op_t     ops[3]   = '{SH, SB, SW};
      logic [31:0] addrs[3] = '{32'h102, 32'h101, 32'h204};
      logic [31:0] wds[3]   = '{32'h1234ABCD, 32'h000000A5, 32'hCAFEF00D};
      logic [31:0] wadr[3]  = '{32'h100, 32'h100, 32'h204};
      logic [3:0]  bes[3]   = '{4'b1100, 4'b0010, 4'b1111};
      logic [31:0] wout[3]  = '{32'hABCDABCD, 32'hA5A5A5A5, 32'hCAFEF00D};
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{addrs[i], 5'd0, 1'b0});
         run_mem(ops[i], addrs[i], wds[i], 5'd0, 1'b0, 2, 32'hFFFFFFFF);
         total_cnt++; if ({obs_we, obs_addr} !== {1'b1, wadr[i]}) $display("[TB] FAIL store%0d_req: got we=%b addr=%h want we=1 addr=%h", i, obs_we, obs_addr, wadr[i]); else pass_cnt++;
         total_cnt++; if (obs_be !== bes[i]) $display("[TB] FAIL store%0d_be: got %b want %b", i, obs_be, bes[i]); else pass_cnt++;
         total_cnt++; if (obs_wdata !== wout[i]) $display("[TB] FAIL store%0d_wdata: got %h want %h", i, obs_wdata, wout[i]); else pass_cnt++;
         total_cnt++; if (obs_stable !== 1'b1) $display("[TB] FAIL store%0d_stable: got %b want 1", i, obs_stable); else pass_cnt++;
         wait_valid(seen);
         total_cnt++; if (!seen) $display("[TB] FAIL store%0d_valid_timeout: got 0 want 1", i); else pass_cnt++;
         e = exp_q.pop_front();
         total_cnt++; if ({data_out_MEM, we_reg_MEM} !== {e.data, e.we_reg}) $display("[TB] FAIL store%0d_result: got %h/%b want %h/%b", i, data_out_MEM, we_reg_MEM, e.data, e.we_reg); else pass_cnt++;
      end
   endtask

   task automatic test_misaligned();
`ifdef MEM_ALIGN_CHECK_EN
      drive_ex(1'b1, LW, 32'h00000102, 32'h0, 5'd7, 1'b1);
      exp_q.push_back('{32'h00000102, 5'd7, 1'b0});
      @(posedge clk);
      @(negedge clk);
      bubble();
      total_cnt++; if ({addr_err, valid_MEM} !== 2'b11) $display("[TB] FAIL misalign_err: got %b want 11", {addr_err, valid_MEM}); else pass_cnt++;
      total_cnt++; if ({dmem_req, stall_req} !== 2'b00) $display("[TB] FAIL misalign_noreq: got %b want 00", {dmem_req, stall_req}); else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++; if ({data_out_MEM, we_reg_MEM} !== {e.data, e.we_reg}) $display("[TB] FAIL misalign_result: got %h/%b want %h/%b", data_out_MEM, we_reg_MEM, e.data, e.we_reg); else pass_cnt++;
      @(posedge clk);
      @(negedge clk);
      total_cnt++; if (addr_err !== 1'b0) $display("[TB] FAIL misalign_clear: got %b want 0", addr_err); else pass_cnt++;
`else
      exp_q.push_back('{32'h11223344, 5'd7, 1'b1});
      run_mem(LW, 32'h00000102, 32'h0, 5'd7, 1'b1, 2, 32'h11223344);
      total_cnt++; if ({obs_addr, obs_be} !== {32'h00000100, 4'b1111}) $display("[TB] FAIL misalign_req: got %h/%b want 00000100/1111", obs_addr, obs_be); else pass_cnt++;
      wait_valid(seen);
      total_cnt++; if (!seen) $display("[TB] FAIL misalign_valid_timeout: got 0 want 1"); else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++; if ({data_out_MEM, we_reg_MEM, addr_err} !== {e.data, e.we_reg, 1'b0}) $display("[TB] FAIL misalign_result: got %h/%b/%b want %h/%b/0", data_out_MEM, we_reg_MEM, addr_err, e.data, e.we_reg); else pass_cnt++;
`endif
   endtask

   task automatic test_reset_busy();
      drive_ex(1'b1, LW, 32'h00000300, 32'h0, 5'd9, 1'b1);
      @(posedge clk);
      @(negedge clk);
      bubble();
      total_cnt++; if ({stall_req, dmem_req} !== 2'b11) $display("[TB] FAIL rbusy_enter: got %b want 11", {stall_req, dmem_req}); else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      total_cnt++; if ({stall_req, dmem_req, valid_MEM} !== 3'b000) $display("[TB] FAIL rbusy_reset: got %b want 000", {stall_req, dmem_req, valid_MEM}); else pass_cnt++;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h77777777;
      @(posedge clk);
      @(negedge clk);
      dmem_ack = 1'b0;
      total_cnt++; if ({valid_MEM, dmem_req, stall_req} !== 3'b000) $display("[TB] FAIL rbusy_stale_ack: got %b want 000", {valid_MEM, dmem_req, stall_req}); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      exp_q.push_back('{32'hAAAA5555, 5'd12, 1'b1});
      run_mem(LW, 32'h00000400, 32'h0, 5'd12, 1'b1, 2, 32'hAAAA5555);
      e = exp_q.pop_front();
      total_cnt++; if ({valid_MEM, data_out_MEM} !== {1'b1, e.data}) $display("[TB] FAIL b2b_first: got %b/%h want 1/%h", valid_MEM, data_out_MEM, e.data); else pass_cnt++;
      exp_q.push_back('{32'h00000404, 5'd0, 1'b0});
      run_mem(SW, 32'h00000404, 32'h0BADF00D, 5'd0, 1'b0, 2, 32'h0);
      total_cnt++; if (obs_stall != 2) $display("[TB] FAIL b2b_second_stall: got %0d want 2", obs_stall); else pass_cnt++;
      total_cnt++; if ({obs_addr, obs_wdata} !== {32'h00000404, 32'h0BADF00D}) $display("[TB] FAIL b2b_second_req: got %h/%h want 00000404/0badf00d", obs_addr, obs_wdata); else pass_cnt++;
      wait_valid(seen);
      e = exp_q.pop_front();
      total_cnt++; if (!seen || data_out_MEM !== e.data) $display("[TB] FAIL b2b_second_result: got %b/%h want 1/%h", seen, data_out_MEM, e.data); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         drive_ex(1'b1, NONE, 32'h1000 + 32'(i), 32'h0, 5'(20 + i), 1'b1);
         exp_q.push_back('{32'h1000 + 32'(i), 5'(20 + i), 1'b1});
         @(posedge clk);
         @(negedge clk);
         e = exp_q.pop_front();
         total_cnt++; if ({stall_req, valid_MEM, data_out_MEM, target_MEM} !== {1'b0, 1'b1, e.data, e.target}) $display("[TB] FAIL b2b_alu%0d: got %b/%b/%h/%0d want 0/1/%h/%0d", i, stall_req, valid_MEM, data_out_MEM, target_MEM, e.data, e.target); else pass_cnt++;
      end
      bubble();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_passthrough();
      test_lw();
      test_loads();
      test_stores();
      test_misaligned();
      test_reset_busy();
      test_back_to_back();
      total_cnt++; if (exp_q.size() != 0) $display("[TB] FAIL scoreboard_drain: got %0d want 0", exp_q.size()); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
